// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS I integer CPU with separate instruction and data buses.
// One instruction commits per enabled clock; branch delay slots are honoured,
// and the core halts itself once the PC it loads is address 0.
module mips_cpu_harvard (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] RESET_NPC = 32'hBFC0_0004;

  // PC and next-PC are stored XOR'ed with their reset values and the run flag
  // is stored inverted, so an all-zero register state is exactly the reset
  // state. A core that powers up with cleared flops runs without reset.
  logic [31:0] pc_q, npc_q;
  logic        halted_q;
  logic [31:0] gpr [0:31];

  logic [31:0] pc, npc, pc_plus4, pc_plus8;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] simm, zimm, rs_val, rt_val;
  logic        wr_en, taken;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, target, br_target, next_npc;

  assign pc       = pc_q ^ RESET_PC;
  assign npc      = npc_q ^ RESET_NPC;
  assign pc_plus4 = pc + 32'd4;
  assign pc_plus8 = pc + 32'd8;

  assign op    = instr_readdata[31:26];
  assign rs    = instr_readdata[25:21];
  assign rt    = instr_readdata[20:16];
  assign rd    = instr_readdata[15:11];
  assign shamt = instr_readdata[10:6];
  assign funct = instr_readdata[5:0];
  assign imm   = instr_readdata[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0000, imm};

  // gpr[0] is cleared on reset and never written, so it always reads zero.
  assign rs_val = gpr[rs];
  assign rt_val = gpr[rt];

  assign br_target = pc_plus4 + {simm[29:0], 2'b00};

  assign active         = ~halted_q;
  assign register_v0    = gpr[2];
  assign instr_address  = pc;
  assign data_address   = rs_val + simm;
  assign data_writedata = rt_val;
  assign data_read      = active && (op == 6'h23);
  assign data_write     = active && (op == 6'h2B);

  // Instruction decode: register write-back and control-flow target.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = 32'h0;
    taken   = 1'b0;
    target  = br_target;
    case (op)
      6'h00: begin
        wr_en = 1'b1;
        case (funct)
          6'h00: wr_data = rt_val << shamt;
          6'h02: wr_data = rt_val >> shamt;
          6'h03: wr_data = $unsigned($signed(rt_val) >>> shamt);
          6'h04: wr_data = rt_val << rs_val[4:0];
          6'h06: wr_data = rt_val >> rs_val[4:0];
          6'h07: wr_data = $unsigned($signed(rt_val) >>> rs_val[4:0]);
          6'h08: begin wr_en = 1'b0; taken = 1'b1; target = rs_val; end
          6'h09: begin taken = 1'b1; target = rs_val; wr_data = pc_plus8; end
          6'h21: wr_data = rs_val + rt_val;
          6'h23: wr_data = rs_val - rt_val;
          6'h24: wr_data = rs_val & rt_val;
          6'h25: wr_data = rs_val | rt_val;
          6'h26: wr_data = rs_val ^ rt_val;
          6'h27: wr_data = ~(rs_val | rt_val);
          6'h2A: wr_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wr_data = {31'h0, rs_val < rt_val};
          default: wr_en = 1'b0;
        endcase
      end
      6'h01: begin
        // Linking REGIMM branches write $31 whether or not they are taken.
        wr_addr = 5'd31;
        wr_data = pc_plus8;
        case (rt)
          5'h00: taken = rs_val[31];
          5'h01: taken = ~rs_val[31];
          5'h10: begin taken = rs_val[31];  wr_en = 1'b1; end
          5'h11: begin taken = ~rs_val[31]; wr_en = 1'b1; end
          default: taken = 1'b0;
        endcase
      end
      6'h02: begin taken = 1'b1; target = {pc_plus4[31:28], instr_readdata[25:0], 2'b00}; end
      6'h03: begin
        taken   = 1'b1;
        target  = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_plus8;
      end
      6'h04: taken = (rs_val == rt_val);
      6'h05: taken = (rs_val != rt_val);
      6'h06: taken = rs_val[31] || (rs_val == 32'h0);
      6'h07: taken = !rs_val[31] && (rs_val != 32'h0);
      6'h09: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val + simm; end
      6'h0A: begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'h0, $signed(rs_val) < $signed(simm)}; end
      6'h0B: begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'h0, rs_val < simm}; end
      6'h0C: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val & zimm; end
      6'h0D: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val | zimm; end
      6'h0E: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val ^ zimm; end
      6'h0F: begin wr_en = 1'b1; wr_addr = rt; wr_data = {imm, 16'h0000}; end
      6'h23: begin wr_en = 1'b1; wr_addr = rt; wr_data = data_readdata; end
      default: wr_en = 1'b0;
    endcase
  end

  assign next_npc = taken ? target : (npc + 32'd4);

  // Architectural state commit: reset wins, otherwise one instruction per enabled edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= 32'h0;
      npc_q    <= 32'h0;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
    end else if (clk_enable && !halted_q) begin
      if (wr_en && (wr_addr != 5'd0)) gpr[wr_addr] <= wr_data;
      pc_q  <= npc_q ^ RESET_PC ^ RESET_NPC;
      npc_q <= next_npc ^ RESET_NPC;
      if (npc == 32'h0) halted_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Directed bench for mips_cpu_harvard: small hand-assembled programs with
// hand-computed results, checked at falling edges.
module tb_mips_cpu_harvard;

  logic        clk, reset, clk_enable;
  logic        active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  logic [31:0] imem [0:31];
  logic [31:0] dmem [0:63];

  int checks = 0;
  int errors = 0;

  logic        halted, seen10;
  int          n_wr, n_rd;
  logic [31:0] last_wa, last_wd;

  mips_cpu_harvard dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  assign instr_readdata = ((instr_address & 32'hFFFF_FF80) == 32'hBFC0_0000)
                          ? imem[instr_address[6:2]] : 32'h0000_0000;
  assign data_readdata  = dmem[data_address[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
    end else if (clk_enable && data_write) begin
      dmem[data_address[7:2]] <= data_writedata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int max_cycles);
    halted = 1'b0; seen10 = 1'b0; n_wr = 0; n_rd = 0;
    last_wa = 32'h0; last_wd = 32'h0;
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_address == 32'h0) begin
        halted = 1'b1;
        break;
      end
      if (instr_address == 32'hBFC0_0010) seen10 = 1'b1;
      if (data_write) begin n_wr++; last_wa = data_address; last_wd = data_writedata; end
      if (data_read) n_rd++;
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_halt_reached"}, {31'h0, halted}, 32'h1);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; clk_enable = 1'b1;
    clear_imem();

    // BLTZAL taken: delay slot runs, 0xBFC00010 skipped, $v0 = 2.
    imem[0] = 32'h2421_0001; imem[1] = 32'h0001_0823; imem[2] = 32'h0430_0002;
    imem[3] = 32'h2442_0001; imem[4] = 32'h2442_0001; imem[5] = 32'h2442_0001;
    imem[6] = 32'h0000_0008; imem[7] = 32'h2400_0000;
    do_reset();
    check("reset_pc", instr_address, 32'hBFC0_0000);
    check("reset_active", {31'h0, active}, 32'h1);
    check("reset_v0", register_v0, 32'h0);
    run_to_halt("bltzal", 100);
    check("bltzal_v0", register_v0, 32'h2);
    check("bltzal_skip", {31'h0, seen10}, 32'h0);
    check("bltzal_active", {31'h0, active}, 32'h0);

    // Same branch, then copy $31 into $v0 to expose the link value.
    clear_imem();
    imem[0] = 32'h2421_0001; imem[1] = 32'h0001_0823; imem[2] = 32'h0430_0002;
    imem[5] = 32'h03E0_1021; imem[6] = 32'h0000_0008;
    do_reset();
    run_to_halt("bltzal_link", 100);
    check("bltzal_link_v0", register_v0, 32'hBFC0_0010);

    // BGEZAL with rs = -1: not taken, link still written, fall-through counts to 3.
    clear_imem();
    imem[0] = 32'h2401_FFFF; imem[1] = 32'h0431_0002; imem[2] = 32'h2442_0001;
    imem[3] = 32'h2442_0001; imem[4] = 32'h2442_0001; imem[5] = 32'h0000_0008;
    do_reset();
    run_to_halt("bgezal", 100);
    check("bgezal_v0", register_v0, 32'h3);
    check("bgezal_visit10", {31'h0, seen10}, 32'h1);

    clear_imem();
    imem[0] = 32'h2401_FFFF; imem[1] = 32'h0431_0002; imem[3] = 32'h03E0_1021;
    imem[4] = 32'h0000_0008;
    do_reset();
    run_to_halt("bgezal_link", 100);
    check("bgezal_link_v0", register_v0, 32'hBFC0_000C);

    // LUI/ORI/ADDIU/SUBU chain; the final ADDIU sits in the JR $0 delay slot.
    clear_imem();
    imem[0] = 32'h3C02_1234; imem[1] = 32'h3442_5000; imem[2] = 32'h2403_0700;
    imem[3] = 32'h0003_2023; imem[4] = 32'h0044_1023; imem[5] = 32'h0000_0008;
    imem[6] = 32'h2442_FF78;
    do_reset();
    run_to_halt("chain", 100);
    check("chain_v0", register_v0, 32'h1234_5678);

    // Same program stalled for five edges after three instructions.
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    clk_enable = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_pc", instr_address, 32'hBFC0_000C);
    check("stall_v0", register_v0, 32'h1234_5000);
    clk_enable = 1'b1;
    run_to_halt("stall", 100);
    check("stall_final_v0", register_v0, 32'h1234_5678);

    // SW 0xDEADBEEF to 0x10, then LW it back into $v0.
    clear_imem();
    imem[0] = 32'h3C05_DEAD; imem[1] = 32'h34A5_BEEF; imem[2] = 32'hAC05_0010;
    imem[3] = 32'h8C02_0010; imem[4] = 32'h0000_0008;
    do_reset();
    run_to_halt("mem", 100);
    check("mem_v0", register_v0, 32'hDEAD_BEEF);
    check("mem_write_pulses", n_wr, 32'd1);
    check("mem_read_pulses", n_rd, 32'd1);
    check("mem_write_addr", last_wa, 32'h0000_0010);
    check("mem_write_data", last_wd, 32'hDEAD_BEEF);
    check("mem_ram_word", dmem[4], 32'hDEAD_BEEF);

    // Halted core stays put and issues no strobes.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("halt_hold_pc", instr_address, 32'h0);
    check("halt_hold_active", {31'h0, active}, 32'h0);
    check("halt_no_strobe", {30'h0, data_read, data_write}, 32'h0);
    check("halt_hold_v0", register_v0, 32'hDEAD_BEEF);

    // One reset edge after halt restarts the core.
    do_reset();
    check("restart_pc", instr_address, 32'hBFC0_0000);
    check("restart_active", {31'h0, active}, 32'h1);
    check("restart_v0", register_v0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
